module_id_ex: RTL and testbench

Decode-to-execute pipeline register for the ARMv8 five-stage core, with integrated load-use hazard detection. Sits directly downstream of the fetch stage's IF/ID register and decoder. It latches decoded operands and control into the EX stage, inserts a bubble and raises a stall to hold the PC and IF/ID when the instruction in EX is a load whose destination the decoding instruction reads. A taken-branch flush from EX kills the entry.

---
 rtl/module_id_ex_pkg.sv | 24 ++
 rtl/module_id_ex_if.sv | 44 ++++
 rtl/module_id_ex_hazard_detect.sv | 24 ++
 rtl/module_id_ex.sv | 107 ++++++++++
 tb/tb_module_id_ex.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/module_id_ex_pkg.sv
// Shared constants for the ID/EX pipeline register: bus widths, control bit map,
// zero-register index and the RUN/STALL view of the stage.
package module_id_ex_pkg;

  localparam int unsigned INST_ADDR_BUS = 64;
  localparam int unsigned REG_BUS       = 64;
  localparam int unsigned CTRL_WIDTH    = 8;

  localparam int unsigned CTRL_REG_WRITE  = 0;
  localparam int unsigned CTRL_MEM_READ   = 1;
  localparam int unsigned CTRL_MEM_WRITE  = 2;
  localparam int unsigned CTRL_MEM_TO_REG = 3;
  localparam int unsigned CTRL_ALU_SRC    = 4;
  localparam int unsigned CTRL_BRANCH     = 5;
  localparam int unsigned CTRL_ALU_OP     = 6;

  localparam logic [4:0] REG_ZR = 5'd31;

  typedef enum logic {
    ST_RUN,
    ST_STALL
  } id_ex_state_t;

endpackage

// File: rtl/module_id_ex_if.sv
// ID-to-EX bundle: decoded ID fields in, latched EX fields, stall and stall count out.
interface module_id_ex_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CTRL_W = 8
);
  logic              id_valid_i;
  logic [ADDR_W-1:0] id_pc_i;
  logic [4:0]        id_rn_i;
  logic [4:0]        id_rm_i;
  logic [4:0]        id_rd_i;
  logic              id_rn_used_i;
  logic              id_rm_used_i;
  logic [DATA_W-1:0] id_rn_data_i;
  logic [DATA_W-1:0] id_rm_data_i;
  logic [DATA_W-1:0] id_imm_i;
  logic [CTRL_W-1:0] id_ctrl_i;
  logic              ex_flush_i;
  logic              stall_o;
  logic              ex_valid_o;
  logic [ADDR_W-1:0] ex_pc_o;
  logic [4:0]        ex_rn_o;
  logic [4:0]        ex_rm_o;
  logic [4:0]        ex_rd_o;
  logic [DATA_W-1:0] ex_rn_data_o;
  logic [DATA_W-1:0] ex_rm_data_o;
  logic [DATA_W-1:0] ex_imm_o;
  logic [CTRL_W-1:0] ex_ctrl_o;
  logic [31:0]       stall_cnt_o;

  modport master (
    output id_valid_i, id_pc_i, id_rn_i, id_rm_i, id_rd_i, id_rn_used_i, id_rm_used_i,
           id_rn_data_i, id_rm_data_i, id_imm_i, id_ctrl_i, ex_flush_i,
    input  stall_o, ex_valid_o, ex_pc_o, ex_rn_o, ex_rm_o, ex_rd_o,
           ex_rn_data_o, ex_rm_data_o, ex_imm_o, ex_ctrl_o, stall_cnt_o
  );

  modport slave (
    input  id_valid_i, id_pc_i, id_rn_i, id_rm_i, id_rd_i, id_rn_used_i, id_rm_used_i,
           id_rn_data_i, id_rm_data_i, id_imm_i, id_ctrl_i, ex_flush_i,
    output stall_o, ex_valid_o, ex_pc_o, ex_rn_o, ex_rm_o, ex_rd_o,
           ex_rn_data_o, ex_rm_data_o, ex_imm_o, ex_ctrl_o, stall_cnt_o
  );
endinterface

// File: rtl/module_id_ex_hazard_detect.sv
// Load-use hazard check: a valid load in EX whose destination is read by the ID instruction.
module module_id_ex_hazard_detect
  import module_id_ex_pkg::*;
(
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       id_valid,
  input  logic [4:0] id_rn,
  input  logic       id_rn_used,
  input  logic [4:0] id_rm,
  input  logic       id_rm_used,
  output logic       hz
);
  logic rn_hit;
  logic rm_hit;

  always_comb begin
    rn_hit = id_rn_used && (id_rn == ex_rd);
    rm_hit = id_rm_used && (id_rm == ex_rd);
    // XZR reads as zero, so a load targeting it can never feed a consumer
    hz = ex_valid && ex_mem_read && id_valid && (ex_rd != REG_ZR) && (rn_hit || rm_hit);
  end
endmodule

// File: rtl/module_id_ex.sv
// ID/EX pipeline register with load-use bubble insertion, flush and saturating stall counter.
module module_id_ex
  import module_id_ex_pkg::*;
#(
  parameter int unsigned ADDR_W = INST_ADDR_BUS,
  parameter int unsigned DATA_W = REG_BUS,
  parameter int unsigned CTRL_W = CTRL_WIDTH
) (
  input logic            clock,
  input logic            reset,
  module_id_ex_if.slave  bus
);
  logic              valid_q;
  logic [ADDR_W-1:0] pc_q;
  logic [4:0]        rn_q;
  logic [4:0]        rm_q;
  logic [4:0]        rd_q;
  logic [DATA_W-1:0] rn_data_q;
  logic [DATA_W-1:0] rm_data_q;
  logic [DATA_W-1:0] imm_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [31:0]       stall_cnt_q;
  logic              hz;
  logic              stall;
  id_ex_state_t      state_q;
  id_ex_state_t      state_d;

  module_id_ex_hazard_detect u_hazard_detect (
    .ex_valid    (valid_q),
    .ex_mem_read (ctrl_q[CTRL_MEM_READ]),
    .ex_rd       (rd_q),
    .id_valid    (bus.id_valid_i),
    .id_rn       (bus.id_rn_i),
    .id_rn_used  (bus.id_rn_used_i),
    .id_rm       (bus.id_rm_i),
    .id_rm_used  (bus.id_rm_used_i),
    .hz          (hz)
  );

  assign stall = hz && !bus.ex_flush_i;

  // After a stall EX holds a bubble, so the hazard cannot persist past one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (stall) state_d = ST_STALL;
      ST_STALL: state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      rn_q      <= '0;
      rm_q      <= '0;
      rd_q      <= '0;
      rn_data_q <= '0;
      rm_data_q <= '0;
      imm_q     <= '0;
      ctrl_q    <= '0;
    end else if (bus.ex_flush_i || hz) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      rn_q      <= '0;
      rm_q      <= '0;
      rd_q      <= '0;
      rn_data_q <= '0;
      rm_data_q <= '0;
      imm_q     <= '0;
      ctrl_q    <= '0;
    end else begin
      valid_q   <= bus.id_valid_i;
      pc_q      <= bus.id_pc_i;
      rn_q      <= bus.id_rn_i;
      rm_q      <= bus.id_rm_i;
      rd_q      <= bus.id_rd_i;
      rn_data_q <= bus.id_rn_data_i;
      rm_data_q <= bus.id_rm_data_i;
      imm_q     <= bus.id_imm_i;
      ctrl_q    <= bus.id_valid_i ? bus.id_ctrl_i : '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                          stall_cnt_q <= '0;
    else if (stall && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign bus.stall_o      = stall;
  assign bus.ex_valid_o   = valid_q;
  assign bus.ex_pc_o      = pc_q;
  assign bus.ex_rn_o      = rn_q;
  assign bus.ex_rm_o      = rm_q;
  assign bus.ex_rd_o      = rd_q;
  assign bus.ex_rn_data_o = rn_data_q;
  assign bus.ex_rm_data_o = rm_data_q;
  assign bus.ex_imm_o     = imm_q;
  assign bus.ex_ctrl_o    = ctrl_q;
  assign bus.stall_cnt_o  = stall_cnt_q;
endmodule

// File: tb/tb_module_id_ex.sv
// Directed bench for module_id_ex: plain flow, load-use, XZR/unused source, flush, reset, saturation.
module tb_module_id_ex;
  localparam logic [7:0] C_ADD = 8'h81;
  localparam logic [7:0] C_LDR = 8'h1B;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  module_id_ex_if #(.ADDR_W(64), .DATA_W(64), .CTRL_W(8)) bus ();

  module_id_ex #(.ADDR_W(64), .DATA_W(64), .CTRL_W(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic present(input logic v, input logic [63:0] pc, input logic [4:0] rn,
                         input logic rnu, input logic [4:0] rm, input logic rmu,
                         input logic [4:0] rd, input logic [7:0] ctrl);
    bus.id_valid_i   = v;
    bus.id_pc_i      = pc;
    bus.id_rn_i      = rn;
    bus.id_rn_used_i = rnu;
    bus.id_rm_i      = rm;
    bus.id_rm_used_i = rmu;
    bus.id_rd_i      = rd;
    bus.id_rn_data_i = pc + 64'h1000;
    bus.id_rm_data_i = pc + 64'h2000;
    bus.id_imm_i     = pc + 64'h3000;
    bus.id_ctrl_i    = ctrl;
    #1;
  endtask

  task automatic expect_ex(input string tag, input logic v, input logic [63:0] pc,
                           input logic [7:0] ctrl);
    check_eq({tag, ".valid"}, {63'd0, bus.ex_valid_o}, {63'd0, v});
    check_eq({tag, ".pc"}, bus.ex_pc_o, pc);
    check_eq({tag, ".ctrl"}, {56'd0, bus.ex_ctrl_o}, {56'd0, ctrl});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    bus.ex_flush_i = 1'b0;
    present(1'b0, 64'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 8'h00);
    #1;
    expect_ex("reset", 1'b0, 64'h0, 8'h00);
    check_eq("reset.stall", {63'd0, bus.stall_o}, 64'd0);
    check_eq("reset.cnt", {32'd0, bus.stall_cnt_o}, 64'd0);
    step();
    reset = 1'b1;

    // Plain flow
    present(1'b1, 64'h0, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, C_ADD);
    check_eq("flow0.stall", {63'd0, bus.stall_o}, 64'd0);
    step();
    expect_ex("flow0", 1'b1, 64'h0, C_ADD);
    check_eq("flow0.rn_data", bus.ex_rn_data_o, 64'h1000);
    check_eq("flow0.rd", {59'd0, bus.ex_rd_o}, 64'd3);
    present(1'b1, 64'h4, 5'd4, 1'b1, 5'd5, 1'b1, 5'd6, C_ADD);
    check_eq("flow1.stall", {63'd0, bus.stall_o}, 64'd0);
    step();
    expect_ex("flow1", 1'b1, 64'h4, C_ADD);
    present(1'b1, 64'h8, 5'd7, 1'b1, 5'd8, 1'b1, 5'd9, C_ADD);
    step();
    expect_ex("flow2", 1'b1, 64'h8, C_ADD);
    check_eq("flow2.imm", bus.ex_imm_o, 64'h3008);
    check_eq("flow.cnt", {32'd0, bus.stall_cnt_o}, 64'd0);

    // Load-use: LDR X2 then ADD X3, X2, X1
    present(1'b1, 64'hC, 5'd1, 1'b1, 5'd0, 1'b0, 5'd2, C_LDR);
    step();
    expect_ex("ldr", 1'b1, 64'hC, C_LDR);
    present(1'b1, 64'h10, 5'd2, 1'b1, 5'd1, 1'b1, 5'd3, C_ADD);
    check_eq("lu.stall", {63'd0, bus.stall_o}, 64'd1);
    step();
    expect_ex("lu.bubble", 1'b0, 64'h0, 8'h00);
    check_eq("lu.cnt", {32'd0, bus.stall_cnt_o}, 64'd1);
    check_eq("lu.stall_drop", {63'd0, bus.stall_o}, 64'd0);
    step();
    expect_ex("lu.add", 1'b1, 64'h10, C_ADD);
    check_eq("lu.cnt2", {32'd0, bus.stall_cnt_o}, 64'd1);

    // LDR XZR then a reader of X31
    present(1'b1, 64'h14, 5'd1, 1'b1, 5'd0, 1'b0, 5'd31, C_LDR);
    step();
    present(1'b1, 64'h18, 5'd31, 1'b1, 5'd1, 1'b1, 5'd4, C_ADD);
    check_eq("xzr.stall", {63'd0, bus.stall_o}, 64'd0);
    step();
    expect_ex("xzr", 1'b1, 64'h18, C_ADD);

    // Unused rm matching the load destination
    present(1'b1, 64'h1C, 5'd1, 1'b1, 5'd0, 1'b0, 5'd2, C_LDR);
    step();
    present(1'b1, 64'h20, 5'd5, 1'b1, 5'd2, 1'b0, 5'd6, C_ADD);
    check_eq("unused.stall", {63'd0, bus.stall_o}, 64'd0);
    step();
    expect_ex("unused", 1'b1, 64'h20, C_ADD);

    // Flush with a simultaneous hazard
    present(1'b1, 64'h24, 5'd1, 1'b1, 5'd0, 1'b0, 5'd2, C_LDR);
    step();
    present(1'b1, 64'h28, 5'd2, 1'b1, 5'd1, 1'b1, 5'd3, C_ADD);
    bus.ex_flush_i = 1'b1;
    #1;
    check_eq("flush.stall", {63'd0, bus.stall_o}, 64'd0);
    step();
    bus.ex_flush_i = 1'b0;
    expect_ex("flush.bubble", 1'b0, 64'h0, 8'h00);
    check_eq("flush.cnt", {32'd0, bus.stall_cnt_o}, 64'd1);
    step();
    expect_ex("flush.after", 1'b1, 64'h28, C_ADD);

    // Invalid ID captured with control cleared
    present(1'b0, 64'h2A, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, C_ADD);
    step();
    expect_ex("invalid", 1'b0, 64'h2A, 8'h00);

    // Reset asserted mid-stall
    present(1'b1, 64'h2C, 5'd1, 1'b1, 5'd0, 1'b0, 5'd2, C_LDR);
    step();
    present(1'b1, 64'h30, 5'd2, 1'b1, 5'd1, 1'b1, 5'd3, C_ADD);
    check_eq("rst.pre_stall", {63'd0, bus.stall_o}, 64'd1);
    #1;
    reset = 1'b0;
    #1;
    expect_ex("rst.async", 1'b0, 64'h0, 8'h00);
    check_eq("rst.stall", {63'd0, bus.stall_o}, 64'd0);
    check_eq("rst.cnt", {32'd0, bus.stall_cnt_o}, 64'd0);
    check_eq("rst.rd", {59'd0, bus.ex_rd_o}, 64'd0);
    step();
    expect_ex("rst.held", 1'b0, 64'h0, 8'h00);
    reset = 1'b1;
    present(1'b1, 64'h40, 5'd7, 1'b1, 5'd8, 1'b1, 5'd3, C_ADD);
    step();
    expect_ex("rst.first", 1'b1, 64'h40, C_ADD);

    // Saturation
    present(1'b1, 64'h50, 5'd1, 1'b1, 5'd0, 1'b0, 5'd2, C_LDR);
    step();
    force dut.stall_cnt_q = 32'hFFFF_FFFD;
    #1;
    release dut.stall_cnt_q;
    #1;
    check_eq("sat.preload", {32'd0, bus.stall_cnt_o}, 64'hFFFF_FFFD);
    for (int unsigned i = 0; i < 3; i++) begin
      present(1'b1, 64'h54, 5'd2, 1'b1, 5'd1, 1'b1, 5'd3, C_ADD);
      check_eq("sat.stall", {63'd0, bus.stall_o}, 64'd1);
      step();
      check_eq("sat.cnt", {32'd0, bus.stall_cnt_o},
               (i == 0) ? 64'hFFFF_FFFE : 64'hFFFF_FFFF);
      if (i < 2) begin
        present(1'b1, 64'h58, 5'd1, 1'b1, 5'd0, 1'b0, 5'd2, C_LDR);
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
